// File: rtl/clk_div_pkg.sv
// Shared definitions for the sample-clock divider controller:
// FSM state encoding and the reset-default divider setting.
package clk_div_pkg;

  // 64 MHz / 125 ~= 512 kHz; high for 62 of the 125 input cycles.
  localparam int DEF_DIV  = 125;
  localparam int DEF_HIGH = 62;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_cfg_check.sv
// Combinational legality check for a divider config.
// A config is usable when the period is at least two input cycles and
// both the high and the low phase last at least one cycle.
module clk_div_cfg_check #(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] div,
  input  logic [CNT_W-1:0] high,
  output logic             ok
);

  // high < div is the same as high <= div-1 without the underflow at div=0.
  always_comb begin
    ok = (div >= CNT_W'(2)) && (high >= CNT_W'(1)) && (high < div);
  end

endmodule

// File: rtl/clk_div_sched_ctrl.sv
// Run-time controller for the system clock divider.
// Derives clk_out from clk_in with a programmable divisor/high-time,
// takes new settings over a valid/ready handshake and swaps them in only
// at period boundaries, so every output period is entirely old or new.
//
// Config handshake: a config transfers on a clk_in edge where cfg_valid
// and cfg_ready are both high. An illegal config is dropped and answered
// with a one-cycle cfg_err; a legal one is held as pending, which drops
// cfg_ready until it becomes active (cfg_applied). Offers made while
// cfg_ready is low are not transfers and are ignored without an error.
module clk_div_sched_ctrl #(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = clk_div_pkg::DEF_DIV,
  parameter int DEF_HIGH = clk_div_pkg::DEF_HIGH
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_err,
  output logic             cfg_applied,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [15:0]      period_cnt,
  output logic [1:0]       dbg_state
);

  import clk_div_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             pend_v_q, pend_v_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic [15:0]      period_cnt_q, period_cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_applied_q, cfg_applied_d;

  logic cfg_ok;
  logic cfg_fire;
  logic at_last;
  logic in_period;
  logic apply;

  clk_div_cfg_check #(
    .CNT_W (CNT_W)
  ) u_cfg_check (
    .div  (cfg_div),
    .high (cfg_high),
    .ok   (cfg_ok)
  );

  // Next-state logic: FSM, period counter, config registers and the
  // output values for the cycle that follows.
  always_comb begin
    cfg_fire  = cfg_valid && !pend_v_q;
    // >= rather than == keeps the counter bounded even if it ever overshoots.
    at_last   = (cnt_q >= (div_q - CNT_W'(1)));
    in_period = (state_q != ST_IDLE);
    // A pending config only takes over where no period is in flight:
    // while idle, or on the wrap from the last count back to zero.
    apply     = pend_v_q && (!in_period || at_last);

    state_d      = state_q;
    cnt_d        = cnt_q;
    period_cnt_d = period_cnt_q;
    div_d        = div_q;
    high_d       = high_q;
    pend_v_d     = pend_v_q;
    pend_div_d   = pend_div_q;
    pend_high_d  = pend_high_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d      = ST_RUN;
          period_cnt_d = 16'd1;
        end
      end
      ST_RUN, ST_STOPPING: begin
        // RUN and STOPPING count identically; they differ only in whether
        // the next boundary starts another period or ends in IDLE.
        if (at_last) begin
          cnt_d = '0;
          if (en) begin
            state_d      = ST_RUN;
            period_cnt_d = period_cnt_q + 16'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = en ? ST_RUN : ST_STOPPING;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // apply needs a pending config and a new transfer needs none,
    // so these two never act in the same cycle.
    if (apply) begin
      div_d    = pend_div_q;
      high_d   = pend_high_q;
      pend_v_d = 1'b0;
    end
    if (cfg_fire && cfg_ok) begin
      pend_v_d    = 1'b1;
      pend_div_d  = cfg_div;
      pend_high_d = cfg_high;
    end

    running_d     = (state_d != ST_IDLE);
    tick_d        = running_d && (cnt_d == '0);
    clk_out_d     = running_d && (cnt_d < high_d);
    cfg_err_d     = cfg_fire && !cfg_ok;
    cfg_applied_d = apply;
  end

  // All state and registered outputs; synchronous active-low reset
  // drops any pending config and restores the default divider.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      div_q         <= CNT_W'(DEF_DIV);
      high_q        <= CNT_W'(DEF_HIGH);
      pend_v_q      <= 1'b0;
      pend_div_q    <= '0;
      pend_high_q   <= '0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      running_q     <= 1'b0;
      period_cnt_q  <= 16'd0;
      cfg_err_q     <= 1'b0;
      cfg_applied_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      high_q        <= high_d;
      pend_v_q      <= pend_v_d;
      pend_div_q    <= pend_div_d;
      pend_high_q   <= pend_high_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      running_q     <= running_d;
      period_cnt_q  <= period_cnt_d;
      cfg_err_q     <= cfg_err_d;
      cfg_applied_q <= cfg_applied_d;
    end
  end

  assign cfg_ready   = !pend_v_q;
  assign cfg_err     = cfg_err_q;
  assign cfg_applied = cfg_applied_q;
  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign running     = running_q;
  assign period_cnt  = period_cnt_q;
  assign dbg_state   = state_q;

endmodule
